// File: rtl/bram_bit_packer_pkg.sv
// Shared state encoding and width helpers for the word-to-bit RAM packer.
package bram_bit_packer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_e;

  function automatic int calc_waddr_w(input int addr_w, input int word_w);
    return addr_w - $clog2(word_w);
  endfunction

  // Beat counter width; a 2-bit word has one beat but still needs a 1-bit counter.
  function automatic int calc_beat_w(input int word_w);
    return (word_w > 2) ? $clog2(word_w / 2) : 1;
  endfunction

endpackage

// File: rtl/bram_bit_packer_asm.sv
// Read-data assembler: drops each beat's Q0/Q1 pair into its even/odd bit slot.
module bram_bit_packer_asm
  import bram_bit_packer_pkg::*;
#(
  parameter  int WORD_W = 16,
  localparam int BW     = calc_beat_w(WORD_W),
  localparam int LW     = $clog2(WORD_W)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_clr,
  input  logic              i_cap,
  input  logic [BW-1:0]     i_beat,
  input  logic              i_q0,
  input  logic              i_q1,
  output logic [WORD_W-1:0] o_data
);

  logic [WORD_W-1:0] r_data;
  logic [LW-1:0]     w_sel0;
  logic [LW-1:0]     w_sel1;

  assign w_sel0 = LW'({i_beat, 1'b0});
  assign w_sel1 = w_sel0 | LW'(1);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_cap) begin
      r_data[w_sel0] <= i_q0;
      r_data[w_sel1] <= i_q1;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/bram_bit_packer.sv
// Word-level initiator for the bit-wide dual-port RAM: even bits on port 0, odd on port 1.
// Build option BRAM_BIT_PACKER_WR_ACK_EN: writes finish with a zero-data response.
//
// state | meaning
// IDLE  | ready for a request, all RAM strobes low
// WRITE | one beat per cycle, two bits written per beat
// READ  | one beat per cycle, Q of the previous beat captured
// DRAIN | no strobes, capture the last beat's Q
// RESP  | rsp_valid held until rsp_ready
module bram_bit_packer
  import bram_bit_packer_pkg::*;
#(
  parameter  int WORD_W  = 16,
  parameter  int ADDR_W  = 14,
  localparam int WADDR_W = calc_waddr_w(ADDR_W, WORD_W),
  localparam int BEATS   = WORD_W / 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WORD_W-1:0]  rsp_rdata,
  output logic [ADDR_W-1:0]  A0,
  output logic [ADDR_W-1:0]  A1,
  output logic               D0,
  output logic               D1,
  output logic               WE0,
  output logic               WE1,
  output logic               WEM0,
  output logic               WEM1,
  output logic               CE0,
  output logic               CE1,
  input  logic               Q0,
  input  logic               Q1
);

  localparam int BW = calc_beat_w(WORD_W);
  localparam int LW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef BRAM_BIT_PACKER_WR_ACK_EN
  localparam state_e WR_DONE = RESP;
`else
  localparam state_e WR_DONE = IDLE;
`endif

  state_e             r_state;
  state_e             w_state_nxt;
  logic [BW-1:0]      r_beat;
  logic [WADDR_W-1:0] r_addr;
  logic [WORD_W-1:0]  r_wdata;

  logic               w_accept;
  logic               w_last;
  logic               w_active;
  logic               w_cap;
  logic [BW-1:0]      w_cap_beat;
  logic [LW-1:0]      w_sel0;
  logic [LW-1:0]      w_sel1;
  logic [ADDR_W-1:0]  w_base;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_last   = (r_beat == LAST_BEAT);
  assign w_active = (r_state == WRITE) || (r_state == READ);
  assign w_sel0   = LW'({r_beat, 1'b0});
  assign w_sel1   = w_sel0 | LW'(1);
  assign w_base   = ADDR_W'(r_addr) << LW;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_beat  <= '0;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if (w_active) begin
      r_beat  <= r_beat + BW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_state_nxt = req_we ? WRITE : READ;
      WRITE:   if (w_last)    w_state_nxt = WR_DONE;
      READ:    if (w_last)    w_state_nxt = DRAIN;
      DRAIN:                  w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Port drive is decoded from registered state only, so reset drops strobes at once.
  always_comb begin
    A0  = '0;
    A1  = '0;
    D0  = 1'b0;
    D1  = 1'b0;
    WE0 = 1'b0;
    WE1 = 1'b0;
    CE0 = 1'b0;
    CE1 = 1'b0;
    if (w_active) begin
      A0  = w_base | ADDR_W'(w_sel0);
      A1  = w_base | ADDR_W'(w_sel1);
      CE0 = 1'b1;
      CE1 = 1'b1;
    end
    if (r_state == WRITE) begin
      D0  = r_wdata[w_sel0];
      D1  = r_wdata[w_sel1];
      WE0 = 1'b1;
      WE1 = 1'b1;
    end
  end

  assign WEM0 = WE0;
  assign WEM1 = WE1;

  // Q lags CE by one cycle: beat k is captured during beat k+1, the last beat in DRAIN.
  assign w_cap      = ((r_state == READ) && (r_beat != '0)) || (r_state == DRAIN);
  assign w_cap_beat = (r_state == DRAIN) ? LAST_BEAT : (r_beat - BW'(1));

  bram_bit_packer_asm #(
    .WORD_W (WORD_W)
  ) u_asm (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_clr  (w_accept),
    .i_cap  (w_cap),
    .i_beat (w_cap_beat),
    .i_q0   (Q0),
    .i_q1   (Q1),
    .o_data (rsp_rdata)
  );

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);

endmodule

// File: tb/tb_bram_bit_packer.sv
// Bench for bram_bit_packer: bit-wide dual-port RAM model plus a word-level shadow memory.
module tb_bram_bit_packer;

  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 14;
  localparam int WADDR_W = 10;
  localparam int BEATS   = 8;
  localparam int NWORDS  = 1024;
  localparam int NBITS   = 16384;

  logic               CLK = 1'b0;
  logic               RSTN = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_we = 1'b0;
  logic [WADDR_W-1:0] req_addr = '0;
  logic [WORD_W-1:0]  req_wdata = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [WORD_W-1:0]  rsp_rdata;
  logic [ADDR_W-1:0]  A0, A1;
  logic               D0, D1, WE0, WE1, WEM0, WEM1, CE0, CE1;
  logic               Q0, Q1;
  logic [5:0]         strb;

  int vecs  = 0;
  int fails = 0;

  logic        mem    [NBITS];
  logic [15:0] shadow [NWORDS];

  bram_bit_packer #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WE0(WE0), .WE1(WE1),
    .WEM0(WEM0), .WEM1(WEM1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  assign strb = {CE1, CE0, WE1, WE0, WEM1, WEM0};

  function automatic logic [15:0] init_word(input int w);
    int t;
    t = w * 40503 + 12345;
    return t[15:0] ^ 16'(w << 5);
  endfunction

  // RAM model: synchronous write, registered read data one cycle after CE.
  initial begin
    logic [15:0] v;
    for (int w = 0; w < NWORDS; w++) begin
      v = init_word(w);
      for (int b = 0; b < 16; b++) mem[w*16+b] <= v[b];
    end
    Q0 <= 1'b0;
    Q1 <= 1'b0;
    forever begin
      @(posedge CLK);
      if (CE0) begin
        if (WE0 && WEM0) mem[A0] <= D0;
        else if (!WE0)   Q0 <= mem[A0];
      end
      if (CE1) begin
        if (WE1 && WEM1) mem[A1] <= D1;
        else if (!WE1)   Q1 <= mem[A1];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All transaction tasks start at a negedge with the DUT idle and end the same way.
  task automatic do_write(input int addr, input logic [15:0] data,
                          input bit keep_valid, input int q_addr);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = WADDR_W'(addr);
    req_wdata = data;
    check("wr_ready", 64'(req_ready), 64'd1);
    @(posedge CLK);
    shadow[addr] = data;
    for (int k = 0; k < BEATS; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        if (keep_valid) begin
          req_we    = 1'b0;
          req_addr  = WADDR_W'(q_addr);
          req_wdata = 16'($urandom);
        end else begin
          req_valid = 1'b0;
        end
      end
      check("wr_a0", 64'(A0), 64'(addr * 16 + 2 * k));
      check("wr_a1", 64'(A1), 64'(addr * 16 + 2 * k + 1));
      check("wr_d", 64'({D1, D0}), 64'((data >> (2 * k)) & 16'h3));
      check("wr_strb", 64'(strb), 64'h3f);
      check("wr_busy", 64'({req_ready, rsp_valid}), 64'd0);
    end
    @(negedge CLK);
    check("wr_end_strb", 64'(strb), 64'd0);
`ifdef BRAM_BIT_PACKER_WR_ACK_EN
    check("wrack_valid", 64'({req_ready, rsp_valid}), 64'b01);
    check("wrack_data", 64'(rsp_rdata), 64'd0);
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("wrack_done", 64'({req_ready, rsp_valid}), 64'b10);
`else
    check("wr_done", 64'({req_ready, rsp_valid}), 64'b10);
`endif
  endtask

  task automatic do_read(input int addr, input int stall);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = WADDR_W'(addr);
    req_wdata = 16'($urandom);
    check("rd_ready", 64'(req_ready), 64'd1);
    @(posedge CLK);
    for (int k = 0; k < BEATS; k++) begin
      @(negedge CLK);
      if (k == 0) req_valid = 1'b0;
      check("rd_a0", 64'(A0), 64'(addr * 16 + 2 * k));
      check("rd_a1", 64'(A1), 64'(addr * 16 + 2 * k + 1));
      check("rd_strb", 64'(strb), 64'h30);
      check("rd_busy", 64'({req_ready, rsp_valid}), 64'd0);
    end
    @(negedge CLK);
    check("drain_strb", 64'(strb), 64'd0);
    check("drain_valid", 64'({req_ready, rsp_valid}), 64'd0);
    @(negedge CLK);
    check("rsp_valid", 64'({req_ready, rsp_valid}), 64'b01);
    check("rsp_data", 64'(rsp_rdata), 64'(shadow[addr]));
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      check("stall_valid", 64'({req_ready, rsp_valid}), 64'b01);
      check("stall_data", 64'(rsp_rdata), 64'(shadow[addr]));
      check("stall_strb", 64'(strb), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    rsp_ready = 1'b0;
    check("rd_done", 64'({req_ready, rsp_valid}), 64'b10);
  endtask

  initial begin
    logic [15:0] bits;
    int          a;
    for (int w = 0; w < NWORDS; w++) shadow[w] = init_word(w);

    @(negedge CLK);
    @(negedge CLK);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'd0);
    check("rst_addr", 64'({A1, A0}), 64'd0);
    check("rst_strb", 64'({D1, D0, strb}), 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    do_write(3, 16'hA5C3, 1'b0, 0);
    do_read(3, 0);

    do_write(5, 16'h1234, 1'b0, 0);
    do_read(5, 5);

    // Request held valid through a write; the queued read must wait for IDLE.
    do_write(7, 16'hBEEF, 1'b1, 7);
    do_read(7, 0);

    do_write(1023, 16'hFFFF, 1'b0, 0);
    do_read(1023, 0);
    for (int b = 0; b < 16; b++) bits[b] = mem[16368 + b];
    check("top_bits", 64'(bits), 64'hFFFF);
    for (int b = 0; b < 16; b++) bits[b] = mem[16352 + b];
    check("w1022_bits", 64'(bits), 64'(init_word(1022)));
    do_read(1022, 1);

    // Reset during READ beat 4.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = WADDR_W'(3);
    @(posedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 0) req_valid = 1'b0;
    end
    check("rst_mid_a0", 64'(A0), 64'(3 * 16 + 8));
    RSTN = 1'b0;
    #1;
    check("rst_mid_strb", 64'(strb), 64'd0);
    check("rst_mid_state", 64'({req_ready, rsp_valid}), 64'b10);
    check("rst_mid_addr", 64'({A1, A0}), 64'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      check("rst_no_rsp", 64'({req_ready, rsp_valid}), 64'b10);
    end
    do_read(3, 0);

    do_write(9, 16'h00FF, 1'b0, 0);
    do_read(9, 2);

    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, NWORDS - 1));
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom), 1'b0, 0);
      else                           do_read(a, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
